// File: rtl/reg_trace_probe.sv
// reg_trace_probe
//   Snoops the register-file write port and records timestamped writes to a
//   selectable set of registers in a first-word-fall-through FIFO. The FIFO
//   drains through a valid/ready port. A sticky breakpoint flag is set on a
//   programmed address/data match.
//
// Ports
//   clk        system clock, all state on the rising edge
//   reset_all  asynchronous active-low reset
//   HALT       freezes the timestamp and capture; draining continues
//   rf_we      register-file write enable
//   rf_waddr   register-file write address
//   rf_wdata   register-file write data
//   watch_mask per-register capture enable (bit i = register i)
//   bp_en      breakpoint enable
//   bp_addr    breakpoint register address
//   bp_data    breakpoint data value
//   bp_clr     clears bp_hit (a same-cycle match wins)
//   tr_valid   FIFO head valid
//   tr_ready   consumer accepts head
//   tr_addr    head entry register address
//   tr_data    head entry data
//   tr_ts      head entry timestamp
//   level      current FIFO occupancy
//   drop_cnt   saturating count of entries lost to a full FIFO
//   bp_hit     sticky breakpoint flag
module reg_trace_probe #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned TS_W   = 16
) (
  input  logic                     clk,
  input  logic                     reset_all,
  input  logic                     HALT,
  input  logic                     rf_we,
  input  logic [ADDR_W-1:0]        rf_waddr,
  input  logic [DATA_W-1:0]        rf_wdata,
  input  logic [(2**ADDR_W)-1:0]   watch_mask,
  input  logic                     bp_en,
  input  logic [ADDR_W-1:0]        bp_addr,
  input  logic [DATA_W-1:0]        bp_data,
  input  logic                     bp_clr,
  output logic                     tr_valid,
  input  logic                     tr_ready,
  output logic [ADDR_W-1:0]        tr_addr,
  output logic [DATA_W-1:0]        tr_data,
  output logic [TS_W-1:0]          tr_ts,
  output logic [$clog2(DEPTH):0]   level,
  output logic [15:0]              drop_cnt,
  output logic                     bp_hit
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam int unsigned ENT_W = ADDR_W + DATA_W + TS_W;

  // Entry storage; contents are not reset, only pointers/level are.
  logic [ENT_W-1:0] r_mem [DEPTH];

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic [TS_W-1:0]  r_ts;
  logic [15:0]      r_drop_cnt;
  logic             r_bp_hit;

  logic             w_qual;
  logic             w_push_req;
  logic             w_full;
  logic             w_valid;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic             w_match;
  logic [ENT_W-1:0] w_head;

  // R0 writes are architecturally discarded, so they are never traced or matched.
  assign w_qual     = rf_we & ~HALT & (rf_waddr != '0);
  assign w_push_req = w_qual & watch_mask[rf_waddr];
  assign w_full     = (r_level == LVL_W'(DEPTH));
  // Valid comes from registered occupancy only: no path from tr_ready.
  assign w_valid    = (r_level != '0);
  assign w_pop      = w_valid & tr_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_push     = w_push_req & (~w_full | w_pop);
  assign w_drop     = w_push_req & w_full & ~w_pop;
  assign w_match    = bp_en & w_qual & (rf_waddr == bp_addr) & (rf_wdata == bp_data);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {rf_waddr, rf_wdata, r_ts};
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_all) begin
    if (!reset_all) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_all) begin
    if (!reset_all) begin
      r_ts <= '0;
    end else if (!HALT) begin
      r_ts <= r_ts + TS_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_all) begin
    if (!reset_all) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != '1)) begin
      r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  // Match takes priority over clear so a coincident hit is never lost.
  always_ff @(posedge clk or negedge reset_all) begin
    if (!reset_all) begin
      r_bp_hit <= 1'b0;
    end else if (w_match) begin
      r_bp_hit <= 1'b1;
    end else if (bp_clr) begin
      r_bp_hit <= 1'b0;
    end
  end

  assign w_head   = r_mem[r_rd_ptr];
  assign tr_valid = w_valid;
  assign tr_addr  = w_head[ENT_W-1 -: ADDR_W];
  assign tr_data  = w_head[TS_W +: DATA_W];
  assign tr_ts    = w_head[TS_W-1:0];
  assign level    = r_level;
  assign drop_cnt = r_drop_cnt;
  assign bp_hit   = r_bp_hit;

endmodule

// File: doc/reg_trace_probe.md
# reg_trace_probe

Parametrised register-file write tracer for the MIPS32 core. It sits beside the datapath register file, snoops its write port, and timestamps writes to a selectable set of registers. It buffers them in a FIFO with a valid/ready drain port and raises a sticky breakpoint flag on a programmed address/data match. It replaces hand-picked register monitoring with a synthesizable, width/depth-generic trace buffer usable in simulation and on hardware.

## Interface
Parameters:
- DATA_W, 32, register data width
- ADDR_W, 5, register address width (2**ADDR_W registers)
- DEPTH, 16, trace FIFO entries; power of two, >= 2
- TS_W, 16, timestamp counter width

Ports:
- clk  in  1  system clock; all state on rising edge
- reset_all  in  1  asynchronous, active-low reset
- HALT  in  1  freezes timestamp counter and capture; drain continues
- rf_we  in  1  register-file write enable
- rf_waddr  in  ADDR_W  register-file write address
- rf_wdata  in  DATA_W  register-file write data
- watch_mask  in  2**ADDR_W  per-register capture enable, bit i = register i
- bp_en  in  1  breakpoint enable
- bp_addr  in  ADDR_W  breakpoint register address
- bp_data  in  DATA_W  breakpoint data value
- bp_clr  in  1  clears bp_hit
- tr_valid  out  1  FIFO head valid
- tr_ready  in  1  consumer accepts head
- tr_addr  out  ADDR_W  head entry register address
- tr_data  out  DATA_W  head entry data
- tr_ts  out  TS_W  head entry timestamp
- level  out  $clog2(DEPTH)+1  current FIFO occupancy
- drop_cnt  out  16  saturating count of entries lost to full FIFO
- bp_hit  out  1  sticky breakpoint flag

## Operation
- Qualified write: rf_we=1, HALT=0, rf_waddr!=0 (R0 writes never traced or matched).
- Push: a qualified write with watch_mask[rf_waddr]=1 pushes {rf_waddr, rf_wdata, ts}. ts is the counter value in that cycle.
- Pop: tr_valid & tr_ready. Pops are allowed during HALT.
- FIFO: circular, read/write pointers wrap modulo DEPTH. Head is presented combinationally from storage (first-word fall-through). tr_addr/tr_data/tr_ts are don't-care while tr_valid=0.
- Full, push without pop: entry discarded, FIFO unchanged, drop_cnt+1, saturating at 16'hFFFF.
- Full, push with pop: both take effect; level stays DEPTH; no drop.
- Empty, push with pop: tr_valid=0, so no pop; push succeeds.
- Timestamp: TS_W-bit counter, +1 every cycle HALT=0, held while HALT=1, wraps 2**TS_W-1 -> 0.
- Breakpoint: bp_en=1 and a qualified write with rf_waddr==bp_addr and rf_wdata==bp_data sets bp_hit. The match ignores watch_mask and FIFO fullness.
- bp_hit stays set until bp_clr. If bp_clr and a new match occur in the same cycle, the match wins and bp_hit stays 1.
- Reset (any time, including mid-drain): pointers, level, ts counter, drop_cnt and bp_hit go to 0 and tr_valid goes to 0 immediately. Storage contents need not be cleared.

## Timing
- Reset values: tr_valid=0, level=0, drop_cnt=0, bp_hit=0. tr_addr/tr_data/tr_ts are undefined (don't-care).
- Capture latency 1: a qualified write sampled at edge N appears as tr_valid=1 and level+1 after edge N.
- Pop takes effect at the sampling edge. The next entry is presented in the following cycle; back-to-back pops sustain 1 entry/cycle.
- bp_hit rises 1 cycle after the matching write edge. drop_cnt updates on the dropping edge.
- The timestamp captured for the first cycle after reset release is 0.
- No combinational path from tr_ready to tr_valid.

## Test plan
- Reset, then writes R1=5, R2=7 in consecutive cycles, mask bits 1,2 set, tr_ready=0 -> level=2, head {1,5,ts=t0}; after one pop, head {2,7,t0+1}.
- Write to R0, and to R3 with mask bit 3=0 -> no push, level unchanged, drop_cnt=0.
- DEPTH=16: 18 pushes with no pops -> level=16, drop_cnt=2. Next push with tr_ready=1 -> level=16, drop_cnt=2, and the oldest entry pops.
- HALT=1 for 10 cycles while writing R4 -> no push, ts frozen; drain continues during HALT. After release, ts resumes from the held value +1.
- bp_en=1, bp_addr=4, bp_data=32'hDEAD: write R4=32'hDEAD with mask=0 -> bp_hit=1 next cycle. bp_clr together with a repeat match keeps bp_hit=1; bp_clr alone clears it.
- Assert reset_all mid-drain with level=5 -> tr_valid=0 and level=0 immediately. After release, ts restarts at 0 and drop_cnt=0.
